// File: rtl/barrel_shift_pkg.sv
// Shared constants and elaboration helpers for the barrel shifter.
package barrel_shift_pkg;

   localparam logic [1:0] MODE_LOGICAL = 2'b00;
   localparam logic [1:0] MODE_ARITH   = 2'b01;
   localparam logic [1:0] MODE_ROTATE  = 2'b10;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   // Ceiling log2, usable in constant expressions.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // True for powers of two of at least 2.
   function automatic bit is_pow2(input int value);
      return (value >= 2) && ((value & (value - 1)) == 0);
   endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One shifter level with a fixed distance, optionally followed by a register.
// Lost bits accumulate through the chain; control travels with the data.
module barrel_shift_stage
   import barrel_shift_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int DISTANCE    = 1,
   parameter int SHIFT_WIDTH = 4,
   parameter int REGISTERED  = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   valid_i,
   input  logic [DATA_WIDTH-1:0]  data_i,
   input  logic                   lost_i,
   input  logic [SHIFT_WIDTH-1:0] amt_i,
   input  logic                   dir_i,
   input  logic [1:0]             mode_i,
   output logic                   valid_o,
   output logic [DATA_WIDTH-1:0]  data_o,
   output logic                   lost_o,
   output logic [SHIFT_WIDTH-1:0] amt_o,
   output logic                   dir_o,
   output logic [1:0]             mode_o
);

   localparam int K = clog2(DISTANCE);
   localparam logic [DATA_WIDTH-1:0] LOW_MASK =
      {{(DATA_WIDTH-DISTANCE){1'b0}}, {DISTANCE{1'b1}}};

   logic [DATA_WIDTH-1:0] data_d;
   logic                  lost_d;

   // Shift by DISTANCE when this level's amount bit is set. The total
   // in-range shift never exceeds W-1, so bits leaving the right end are
   // always original data bits, never sign copies.
   always_comb begin
      data_d = data_i;
      lost_d = lost_i;
      if (amt_i[K]) begin
         if (mode_i == MODE_ROTATE) begin
            if (dir_i == DIR_RIGHT)
               data_d = (data_i >> DISTANCE) | (data_i << (DATA_WIDTH - DISTANCE));
            else
               data_d = (data_i << DISTANCE) | (data_i >> (DATA_WIDTH - DISTANCE));
         end else if (dir_i == DIR_LEFT) begin
            data_d = data_i << DISTANCE;
            lost_d = lost_i | (|(data_i >> (DATA_WIDTH - DISTANCE)));
         end else begin
            if (mode_i == MODE_ARITH)
               data_d = unsigned'($signed(data_i) >>> DISTANCE);
            else
               data_d = data_i >> DISTANCE;
            lost_d = lost_i | (|(data_i & LOW_MASK));
         end
      end
   end

   generate
      if (REGISTERED != 0) begin : g_reg
         logic                   valid_q;
         logic [DATA_WIDTH-1:0]  data_q;
         logic                   lost_q;
         logic [SHIFT_WIDTH-1:0] amt_q;
         logic                   dir_q;
         logic [1:0]             mode_q;

         // Level register; en freezes it, valid included.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               valid_q <= 1'b0;
               data_q  <= '0;
               lost_q  <= 1'b0;
               amt_q   <= '0;
               dir_q   <= 1'b0;
               mode_q  <= '0;
            end else if (en) begin
               valid_q <= valid_i;
               data_q  <= data_d;
               lost_q  <= lost_d;
               amt_q   <= amt_i;
               dir_q   <= dir_i;
               mode_q  <= mode_i;
            end
         end

         assign valid_o = valid_q;
         assign data_o  = data_q;
         assign lost_o  = lost_q;
         assign amt_o   = amt_q;
         assign dir_o   = dir_q;
         assign mode_o  = mode_q;
      end else begin : g_comb
         logic unused_clk;
         assign unused_clk = ^{clk, rst, en};

         assign valid_o = valid_i;
         assign data_o  = data_d;
         assign lost_o  = lost_d;
         assign amt_o   = amt_i;
         assign dir_o   = dir_i;
         assign mode_o  = mode_i;
      end
   endgenerate

endmodule

// File: rtl/barrel_shift.sv
// Runtime-programmable pipelined barrel shifter: input register, an
// over-range pre-step, then log2(W) fixed-distance levels.
module barrel_shift
   import barrel_shift_pkg::*;
#(
   parameter string ARCHITECTURE = "BEHAVIORAL",
   parameter int    DATA_WIDTH   = 8,
   parameter int    SHIFT_WIDTH  = 4,
   parameter int    REG_EVERY    = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   in_valid,
   input  logic [DATA_WIDTH-1:0]  data_in,
   input  logic [SHIFT_WIDTH-1:0] shift_amt,
   input  logic                   shift_dir,
   input  logic [1:0]             shift_mode,
   output logic [DATA_WIDTH-1:0]  data_out,
   output logic                   out_valid,
   output logic                   out_lost
);

   localparam int L = clog2(DATA_WIDTH);

   generate
      if (!is_pow2(DATA_WIDTH)) begin : g_bad_width
         $error("barrel_shift: DATA_WIDTH must be a power of two >= 2");
      end
      if (SHIFT_WIDTH != L + 1) begin : g_bad_shift_width
         $error("barrel_shift: SHIFT_WIDTH must equal log2(DATA_WIDTH)+1");
      end
      if (REG_EVERY < 1 || REG_EVERY > L) begin : g_bad_reg_every
         $error("barrel_shift: REG_EVERY must be in 1..log2(DATA_WIDTH)");
      end
      if (ARCHITECTURE != "BEHAVIORAL") begin : g_bad_arch
         $error("barrel_shift: unsupported ARCHITECTURE");
      end
   endgenerate

   logic                   vld_q;
   logic [DATA_WIDTH-1:0]  data_q;
   logic [SHIFT_WIDTH-1:0] amt_q;
   logic                   dir_q;
   logic [1:0]             mode_q;

   // Input register: every field captured on each enabled edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q  <= 1'b0;
         data_q <= '0;
         amt_q  <= '0;
         dir_q  <= 1'b0;
         mode_q <= '0;
      end else if (en) begin
         vld_q  <= in_valid;
         data_q <= data_in;
         amt_q  <= shift_amt;
         dir_q  <= shift_dir;
         mode_q <= shift_mode;
      end
   end

   logic [L:0][DATA_WIDTH-1:0]  s_data;
   logic [L:0]                  s_lost;
   logic [L:0]                  s_vld;
   logic [L:0][SHIFT_WIDTH-1:0] s_amt;
   logic [L:0]                  s_dir;
   logic [L:0][1:0]             s_mode;

   // Over-range amounts (top amount bit set, non-rotate) resolve here in one
   // step: the result is pure fill and the levels see a zero amount. For
   // arithmetic right the sign bit survives as the fill, so only the bits
   // below it count as discarded.
   always_comb begin
      s_data[0] = data_q;
      s_lost[0] = 1'b0;
      s_amt[0]  = amt_q;
      if (amt_q[SHIFT_WIDTH-1] && (mode_q != MODE_ROTATE)) begin
         s_amt[0] = '0;
         if ((dir_q == DIR_RIGHT) && (mode_q == MODE_ARITH)) begin
            s_data[0] = {DATA_WIDTH{data_q[DATA_WIDTH-1]}};
            s_lost[0] = |data_q[DATA_WIDTH-2:0];
         end else begin
            s_data[0] = '0;
            s_lost[0] = |data_q;
         end
      end
   end

   assign s_vld[0]  = vld_q;
   assign s_dir[0]  = dir_q;
   assign s_mode[0] = mode_q;

   generate
      for (genvar k = 0; k < L; k++) begin : g_lvl
         localparam int REG = (((k + 1) % REG_EVERY) == 0 || k == L - 1) ? 1 : 0;
         barrel_shift_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .DISTANCE   (1 << k),
            .SHIFT_WIDTH(SHIFT_WIDTH),
            .REGISTERED (REG)
         ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .valid_i(s_vld[k]),
            .data_i (s_data[k]),
            .lost_i (s_lost[k]),
            .amt_i  (s_amt[k]),
            .dir_i  (s_dir[k]),
            .mode_i (s_mode[k]),
            .valid_o(s_vld[k+1]),
            .data_o (s_data[k+1]),
            .lost_o (s_lost[k+1]),
            .amt_o  (s_amt[k+1]),
            .dir_o  (s_dir[k+1]),
            .mode_o (s_mode[k+1])
         );
      end
   endgenerate

   logic unused_ctrl;
   assign unused_ctrl = ^{s_amt[L], s_dir[L], s_mode[L]};

   assign data_out  = s_data[L];
   assign out_valid = s_vld[L];
   assign out_lost  = s_lost[L];

endmodule

// File: tb/tb_barrel_shift.sv
// Directed bench for barrel_shift: REG_EVERY=1 (latency 4) and REG_EVERY=3
// (latency 2) instances share stimulus.
module tb_barrel_shift;

   logic       clk, rst, en, in_valid, shift_dir;
   logic [7:0] data_in;
   logic [3:0] shift_amt;
   logic [1:0] shift_mode;
   logic [7:0] data_out, data_out3;
   logic       out_valid, out_lost, out_valid3, out_lost3;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] d;
      logic [3:0] a;
      logic       dir;
      logic [1:0] m;
      logic [7:0] e;
      logic       l;
   } vec_t;

   barrel_shift #(.DATA_WIDTH(8), .SHIFT_WIDTH(4), .REG_EVERY(1)) dut (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .data_in(data_in),
      .shift_amt(shift_amt), .shift_dir(shift_dir), .shift_mode(shift_mode),
      .data_out(data_out), .out_valid(out_valid), .out_lost(out_lost));

   barrel_shift #(.DATA_WIDTH(8), .SHIFT_WIDTH(4), .REG_EVERY(3)) dut3 (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .data_in(data_in),
      .shift_amt(shift_amt), .shift_dir(shift_dir), .shift_mode(shift_mode),
      .data_out(data_out3), .out_valid(out_valid3), .out_lost(out_lost3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one valid sample and watch both outputs for up to 8 edges.
   task automatic run_sample(input logic [7:0] d, input logic [3:0] a, input logic dir,
                             input logic [1:0] m, output int lat, output logic [7:0] od,
                             output logic ol, output int lat3, output logic [7:0] od3,
                             output logic ol3);
      lat = -1; lat3 = -1; od = '0; ol = 1'b0; od3 = '0; ol3 = 1'b0;
      data_in = d; shift_amt = a; shift_dir = dir; shift_mode = m;
      in_valid = 1'b1; en = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (out_valid && lat < 0) begin lat = c; od = data_out; ol = out_lost; end
         if (out_valid3 && lat3 < 0) begin lat3 = c; od3 = data_out3; ol3 = out_lost3; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; in_valid = 1'b0; data_in = '0;
      shift_amt = '0; shift_dir = 1'b0; shift_mode = 2'b00;
      #2;
      checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_out); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      checks++; if (out_lost !== 1'b0) begin errors++; $display("FAIL reset_lost: got %b expected 0", out_lost); end
      repeat (2) @(posedge clk);
      #1;
      checks++; if (out_valid3 !== 1'b0 || data_out3 !== 8'h00) begin
         errors++; $display("FAIL reset_held_r3: got v=%b d=%h expected v=0 d=00", out_valid3, data_out3); end
      rst = 1'b0;
   endtask

   task automatic test_logical();
      vec_t v [3];
      int lat, lat3; logic [7:0] od, od3; logic ol, ol3;
      v[0] = '{8'h55, 4'd1, 1'b0, 2'b00, 8'hAA, 1'b0};
      v[1] = '{8'hF0, 4'd2, 1'b0, 2'b00, 8'hC0, 1'b1};
      v[2] = '{8'hF0, 4'd3, 1'b1, 2'b00, 8'h1E, 1'b0};
      for (int i = 0; i < 3; i++) begin
         run_sample(v[i].d, v[i].a, v[i].dir, v[i].m, lat, od, ol, lat3, od3, ol3);
         checks++; if (lat !== 4) begin errors++; $display("FAIL logical_lat[%0d]: got %0d expected 4", i, lat); end
         checks++; if (od !== v[i].e) begin errors++; $display("FAIL logical_data[%0d]: got %h expected %h", i, od, v[i].e); end
         checks++; if (ol !== v[i].l) begin errors++; $display("FAIL logical_lost[%0d]: got %b expected %b", i, ol, v[i].l); end
         checks++; if (lat3 !== 2) begin errors++; $display("FAIL logical_lat_r3[%0d]: got %0d expected 2", i, lat3); end
         checks++; if (od3 !== v[i].e || ol3 !== v[i].l) begin
            errors++; $display("FAIL logical_r3[%0d]: got %h/%b expected %h/%b", i, od3, ol3, v[i].e, v[i].l); end
      end
   endtask

   task automatic test_arith();
      vec_t v [2];
      int lat, lat3; logic [7:0] od, od3; logic ol, ol3;
      v[0] = '{8'h96, 4'd2,  1'b1, 2'b01, 8'hE5, 1'b1};
      v[1] = '{8'h80, 4'd12, 1'b1, 2'b01, 8'hFF, 1'b0};
      for (int i = 0; i < 2; i++) begin
         run_sample(v[i].d, v[i].a, v[i].dir, v[i].m, lat, od, ol, lat3, od3, ol3);
         checks++; if (lat !== 4) begin errors++; $display("FAIL arith_lat[%0d]: got %0d expected 4", i, lat); end
         checks++; if (od !== v[i].e) begin errors++; $display("FAIL arith_data[%0d]: got %h expected %h", i, od, v[i].e); end
         checks++; if (ol !== v[i].l) begin errors++; $display("FAIL arith_lost[%0d]: got %b expected %b", i, ol, v[i].l); end
         checks++; if (lat3 !== 2 || od3 !== v[i].e || ol3 !== v[i].l) begin
            errors++; $display("FAIL arith_r3[%0d]: got %0d/%h/%b expected 2/%h/%b", i, lat3, od3, ol3, v[i].e, v[i].l); end
      end
   endtask

   task automatic test_rotate();
      vec_t v [3];
      int lat, lat3; logic [7:0] od, od3; logic ol, ol3;
      v[0] = '{8'h81, 4'd1, 1'b0, 2'b10, 8'h03, 1'b0};
      v[1] = '{8'h81, 4'd9, 1'b1, 2'b10, 8'hC0, 1'b0};
      v[2] = '{8'hB4, 4'd7, 1'b0, 2'b10, 8'h5A, 1'b0};
      for (int i = 0; i < 3; i++) begin
         run_sample(v[i].d, v[i].a, v[i].dir, v[i].m, lat, od, ol, lat3, od3, ol3);
         checks++; if (lat !== 4) begin errors++; $display("FAIL rotate_lat[%0d]: got %0d expected 4", i, lat); end
         checks++; if (od !== v[i].e) begin errors++; $display("FAIL rotate_data[%0d]: got %h expected %h", i, od, v[i].e); end
         checks++; if (ol !== v[i].l) begin errors++; $display("FAIL rotate_lost[%0d]: got %b expected %b", i, ol, v[i].l); end
         checks++; if (lat3 !== 2 || od3 !== v[i].e || ol3 !== v[i].l) begin
            errors++; $display("FAIL rotate_r3[%0d]: got %0d/%h/%b expected 2/%h/%b", i, lat3, od3, ol3, v[i].e, v[i].l); end
      end
   endtask

   task automatic test_overrange();
      vec_t v [4];
      int lat, lat3; logic [7:0] od, od3; logic ol, ol3;
      v[0] = '{8'hFF, 4'd8,  1'b1, 2'b00, 8'h00, 1'b1};
      v[1] = '{8'h01, 4'd15, 1'b0, 2'b00, 8'h00, 1'b1};
      v[2] = '{8'h0F, 4'd4,  1'b0, 2'b11, 8'hF0, 1'b0};
      v[3] = '{8'h00, 4'd9,  1'b0, 2'b11, 8'h00, 1'b0};
      for (int i = 0; i < 4; i++) begin
         run_sample(v[i].d, v[i].a, v[i].dir, v[i].m, lat, od, ol, lat3, od3, ol3);
         checks++; if (lat !== 4) begin errors++; $display("FAIL over_lat[%0d]: got %0d expected 4", i, lat); end
         checks++; if (od !== v[i].e) begin errors++; $display("FAIL over_data[%0d]: got %h expected %h", i, od, v[i].e); end
         checks++; if (ol !== v[i].l) begin errors++; $display("FAIL over_lost[%0d]: got %b expected %b", i, ol, v[i].l); end
         checks++; if (lat3 !== 2 || od3 !== v[i].e || ol3 !== v[i].l) begin
            errors++; $display("FAIL over_r3[%0d]: got %0d/%h/%b expected 2/%h/%b", i, lat3, od3, ol3, v[i].e, v[i].l); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] got [$];
      logic [7:0] got3 [$];
      logic [7:0] snap_d, snap_d3;
      logic       snap_v, snap_v3;
      int si;
      si = 0; shift_amt = 4'd1; shift_dir = 1'b0; shift_mode = 2'b00;
      for (int c = 0; c < 20; c++) begin
         en = !(c == 4 || c == 5);
         if (en && si < 8) begin in_valid = 1'b1; data_in = 8'(si + 1); si++; end
         else in_valid = 1'b0;
         snap_d = data_out; snap_v = out_valid; snap_d3 = data_out3; snap_v3 = out_valid3;
         @(posedge clk); #1;
         if (!en) begin
            checks++; if (data_out !== snap_d || out_valid !== snap_v) begin
               errors++; $display("FAIL stall_freeze c=%0d: got %h/%b expected %h/%b", c, data_out, out_valid, snap_d, snap_v); end
            checks++; if (data_out3 !== snap_d3 || out_valid3 !== snap_v3) begin
               errors++; $display("FAIL stall_freeze_r3 c=%0d: got %h/%b expected %h/%b", c, data_out3, out_valid3, snap_d3, snap_v3); end
         end else begin
            if (out_valid) got.push_back(data_out);
            if (out_valid3) got3.push_back(data_out3);
         end
      end
      en = 1'b1; in_valid = 1'b0;
      checks++; if (got.size() != 8) begin errors++; $display("FAIL stream_count: got %0d expected 8", got.size()); end
      checks++; if (got3.size() != 8) begin errors++; $display("FAIL stream_count_r3: got %0d expected 8", got3.size()); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (i >= got.size() || got[i] !== 8'((i + 1) << 1)) begin
            errors++; $display("FAIL stream_data[%0d]: got %h expected %h", i, (i < got.size()) ? got[i] : 8'hxx, 8'((i + 1) << 1)); end
         checks++; if (i >= got3.size() || got3[i] !== 8'((i + 1) << 1)) begin
            errors++; $display("FAIL stream_data_r3[%0d]: got %h expected %h", i, (i < got3.size()) ? got3[i] : 8'hxx, 8'((i + 1) << 1)); end
      end
   endtask

   task automatic test_reset_midstream();
      int lat, lat3; logic [7:0] od, od3; logic ol, ol3;
      en = 1'b1; shift_amt = 4'd0; shift_dir = 1'b0; shift_mode = 2'b00;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; data_in = 8'(8'h11 * (i + 1));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || data_out !== 8'h11) begin
         errors++; $display("FAIL midrst_before: got %b/%h expected 1/11", out_valid, data_out); end
      #3 rst = 1'b1;
      #1;
      checks++; if (data_out !== 8'h00 || out_valid !== 1'b0 || out_lost !== 1'b0) begin
         errors++; $display("FAIL midrst_async: got %h/%b/%b expected 00/0/0", data_out, out_valid, out_lost); end
      checks++; if (data_out3 !== 8'h00 || out_valid3 !== 1'b0) begin
         errors++; $display("FAIL midrst_async_r3: got %h/%b expected 00/0", data_out3, out_valid3); end
      @(posedge clk); #1;
      rst = 1'b0;
      run_sample(8'h05, 4'd2, 1'b0, 2'b00, lat, od, ol, lat3, od3, ol3);
      checks++; if (lat !== 4 || od !== 8'h14 || ol !== 1'b0) begin
         errors++; $display("FAIL midrst_after: got %0d/%h/%b expected 4/14/0", lat, od, ol); end
      checks++; if (lat3 !== 2 || od3 !== 8'h14) begin
         errors++; $display("FAIL midrst_after_r3: got %0d/%h expected 2/14", lat3, od3); end
   endtask

   initial begin
      test_reset();
      test_logical();
      test_arith();
      test_rotate();
      test_overrange();
      test_back_to_back();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
